// File: rtl/coin_acceptor_pkg.sv
// Shared definitions for the coin acceptor: coin codes, FSM encodings, nominal diameters
// and the diameter classifier.
package coin_acceptor_pkg;

  localparam int unsigned DIAM_W  = 4;
  localparam int unsigned CODE_W  = 2;
  localparam int unsigned STATE_W = 3;

  typedef logic [CODE_W-1:0] coin_code_t;

  localparam coin_code_t COIN_NONE = CODE_W'(0);
  localparam coin_code_t COIN_25   = CODE_W'(1);
  localparam coin_code_t COIN_50   = CODE_W'(2);

  localparam logic [STATE_W-1:0] S_IDLE       = 3'd0;
  localparam logic [STATE_W-1:0] S_DEBOUNCE   = 3'd1;
  localparam logic [STATE_W-1:0] S_MEASURE    = 3'd2;
  localparam logic [STATE_W-1:0] S_EMIT       = 3'd3;
  localparam logic [STATE_W-1:0] S_GAP        = 3'd4;
  localparam logic [STATE_W-1:0] S_REJECT     = 3'd5;
  localparam logic [STATE_W-1:0] S_WAIT_CLEAR = 3'd6;

  localparam int DIAM_25_NOM  = 9;
  localparam int DIAM_50_NOM  = 11;
  localparam int DIAM_100_NOM = 13;

  // Two back-to-back diameter samples taken while the coin sits in the slot.
  typedef struct packed {
    logic [DIAM_W-1:0] s0;
    logic [DIAM_W-1:0] s1;
  } diam_pair_t;

  typedef enum logic [1:0] {CLS_25, CLS_50, CLS_100, CLS_BAD} coin_class_t;

  // Lowest denomination is tested first so it wins where tolerance windows overlap.
  function automatic coin_class_t classify(input logic [DIAM_W-1:0] diam,
                                           input int n25, input int n50,
                                           input int n100, input int tol);
    int d;
    d = int'(diam);
    if (d >= n25 - tol && d <= n25 + tol)   return CLS_25;
    if (d >= n50 - tol && d <= n50 + tol)   return CLS_50;
    if (d >= n100 - tol && d <= n100 + tol) return CLS_100;
    return CLS_BAD;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin slot sensors in, coin code / strobe / gate drive out.
interface coin_acceptor_if;
  import coin_acceptor_pkg::*;

  logic              coin_det_raw;
  logic [DIAM_W-1:0] coin_diam;
  coin_code_t        moeda_in;
  logic              sensor_moedas;
  logic              reject_gate;
  logic              busy;

  modport slave (
    input  coin_det_raw, coin_diam,
    output moeda_in, sensor_moedas, reject_gate, busy
  );

  modport master (
    output coin_det_raw, coin_diam,
    input  moeda_in, sensor_moedas, reject_gate, busy
  );
endinterface

// File: rtl/coin_acceptor_debouncer.sv
// Two-flop synchronizer plus a qualifier that flips the clean level after DEB_CYCLES
// consecutive samples disagreeing with it; rise_c/fall_c fire on the qualifying sample.
module coin_acceptor_debouncer #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic det_raw,
  output logic det_s,
  output logic det_q,
  output logic rise_c,
  output logic fall_c
);
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES) + 1;

  logic             sync1;
  logic [CNT_W-1:0] cnt_q;
  logic             flip_c;

  assign flip_c = (det_s != det_q) && (cnt_q == CNT_W'(DEB_CYCLES - 1));
  assign rise_c = flip_c & det_s;
  assign fall_c = flip_c & ~det_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      det_s <= 1'b0;
      det_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1 <= det_raw;
      det_s <= sync1;
      if (det_s == det_q) begin
        cnt_q <= '0;
      end else if (flip_c) begin
        cnt_q <= '0;
        det_q <= det_s;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front-end: debounce, diameter measurement, classification and emission.
// Define COIN_ACCEPT_100_EN to accept R$1.00 as two consecutive R$0.50 emissions.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned EMIT_CYCLES = 3,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned REJ_CYCLES  = 8,
  parameter int          DIAM_25     = DIAM_25_NOM,
  parameter int          DIAM_50     = DIAM_50_NOM,
  parameter int          DIAM_100    = DIAM_100_NOM,
  parameter int          DIAM_TOL    = 0
) (
  input  logic           clk,
  input  logic           reset,
  coin_acceptor_if.slave bus
);
  localparam int unsigned CNT_MAX_EG = (EMIT_CYCLES > GAP_CYCLES) ? EMIT_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_MAX    = (CNT_MAX_EG > REJ_CYCLES) ? CNT_MAX_EG : REJ_CYCLES;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX) + 1;
  localparam int unsigned TRY_MAX    = 4;
  localparam int unsigned TRY_W      = $clog2(TRY_MAX) + 1;

  logic               det_s, det_q, rise_c, fall_c;
  logic [STATE_W-1:0] state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [1:0]         phase_q, phase_nxt;
  logic [TRY_W-1:0]   tries_q, tries_nxt;
  diam_pair_t         meas_q, meas_nxt;
  coin_code_t         code_q, code_nxt;
  logic               pend_q, pend_nxt;
  coin_code_t         moeda_nxt;
  logic               sensor_nxt, reject_nxt, busy_nxt;
  coin_class_t        cls_c;

  coin_acceptor_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk    (clk),
    .reset  (reset),
    .det_raw(bus.coin_det_raw),
    .det_s  (det_s),
    .det_q  (det_q),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  assign cls_c = classify(meas_q.s0, DIAM_25, DIAM_50, DIAM_100, DIAM_TOL);

  // State and output registers; outputs mirror the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      phase_q           <= '0;
      tries_q           <= '0;
      meas_q            <= '0;
      code_q            <= COIN_NONE;
      pend_q            <= 1'b0;
      bus.moeda_in      <= COIN_NONE;
      bus.sensor_moedas <= 1'b0;
      bus.reject_gate   <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      state_q           <= state_nxt;
      cnt_q             <= cnt_nxt;
      phase_q           <= phase_nxt;
      tries_q           <= tries_nxt;
      meas_q            <= meas_nxt;
      code_q            <= code_nxt;
      pend_q            <= pend_nxt;
      bus.moeda_in      <= moeda_nxt;
      bus.sensor_moedas <= sensor_nxt;
      bus.reject_gate   <= reject_nxt;
      bus.busy          <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    phase_nxt = phase_q;
    tries_nxt = tries_q;
    meas_nxt  = meas_q;
    code_nxt  = code_q;
    pend_nxt  = pend_q;

    case (state_q)
      S_IDLE, S_DEBOUNCE: begin
        if (rise_c) begin
          state_nxt = S_MEASURE;
          phase_nxt = '0;
          tries_nxt = '0;
        end else if (state_q == S_IDLE && det_s) begin
          state_nxt = S_DEBOUNCE;
        end else if (!det_s) begin
          state_nxt = S_IDLE;
        end
      end

      // Two samples, then an evaluation cycle; disagreeing samples cost one try.
      S_MEASURE: begin
        case (phase_q)
          2'd0: begin
            meas_nxt.s0 = bus.coin_diam;
            phase_nxt   = 2'd1;
          end
          2'd1: begin
            meas_nxt.s1 = bus.coin_diam;
            phase_nxt   = 2'd2;
          end
          default: begin
            phase_nxt = 2'd0;
            cnt_nxt   = '0;
            if (meas_q.s0 != meas_q.s1) begin
              if (tries_q == TRY_W'(TRY_MAX - 1)) state_nxt = S_REJECT;
              else                                tries_nxt = tries_q + TRY_W'(1);
            end else begin
              case (cls_c)
                CLS_25: begin
                  state_nxt = S_EMIT;
                  code_nxt  = COIN_25;
                end
                CLS_50: begin
                  state_nxt = S_EMIT;
                  code_nxt  = COIN_50;
                end
`ifdef COIN_ACCEPT_100_EN
                CLS_100: begin
                  state_nxt = S_EMIT;
                  code_nxt  = COIN_50;
                  pend_nxt  = 1'b1;
                end
`endif
                default: state_nxt = S_REJECT;
              endcase
            end
          end
        endcase
      end

      S_EMIT: begin
        if (cnt_q == CNT_W'(EMIT_CYCLES - 1)) begin
          state_nxt = S_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_nxt = '0;
          if (pend_q) begin
            state_nxt = S_EMIT;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = S_WAIT_CLEAR;
          end
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      S_REJECT: begin
        if (cnt_q == CNT_W'(REJ_CYCLES - 1)) begin
          state_nxt = S_WAIT_CLEAR;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      // The slot must read empty for a full debounce window before the next coin.
      S_WAIT_CLEAR: begin
        if (fall_c || (!det_q && !det_s)) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase

    sensor_nxt = (state_nxt == S_EMIT);
    moeda_nxt  = sensor_nxt ? code_nxt : COIN_NONE;
    reject_nxt = (state_nxt == S_REJECT);
    busy_nxt   = (state_nxt != S_IDLE);
  end
endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus queues expected pulses, a monitor measures
// every strobe / reject pulse and compares kind, code, length and start cycle.
module tb_coin_acceptor;
  import coin_acceptor_pkg::*;

  typedef struct {
    int kind;
    int code;
    int len;
    int abs_start;
    int gap;
  } exp_t;

  localparam int K_EMIT = 0;
  localparam int K_REJ  = 1;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  bit   in_p;
  int   p_kind, p_code, p_len, p_start, last_end, act_kind;

  coin_acceptor_if bus();

  coin_acceptor dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int code, input int len,
                      input int abs_start, input int gap);
    exp_t e;
    e.kind = kind; e.code = code; e.len = len; e.abs_start = abs_start; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic coin_on(input logic [3:0] d, output int n);
    @(posedge clk); #1;
    bus.coin_det_raw = 1'b1;
    bus.coin_diam    = d;
    n = cyc;
  endtask

  task automatic coin_hold(input logic [3:0] d, input int cycles, input bit alt);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (alt) bus.coin_diam = (bus.coin_diam == d) ? d + 4'd1 : d;
    end
  endtask

  task automatic coin_off();
    bus.coin_det_raw = 1'b0;
    bus.coin_diam    = 4'd0;
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (bus.busy && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    check({name, "_idle"}, int'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: measures each pulse and scores it against the head of the queue.
  initial begin
    in_p = 1'b0;
    last_end = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_p = 1'b0;
      end else begin
        check("inv_code_without_strobe", int'(!bus.sensor_moedas && bus.moeda_in != COIN_NONE), 0);
        check("inv_strobe_and_reject", int'(bus.sensor_moedas && bus.reject_gate), 0);
        act_kind = bus.sensor_moedas ? K_EMIT : (bus.reject_gate ? K_REJ : -1);
        if (!in_p && act_kind >= 0) begin
          in_p    = 1'b1;
          p_kind  = act_kind;
          p_code  = int'(bus.moeda_in);
          p_len   = 1;
          p_start = cyc;
        end else if (in_p && act_kind >= 0) begin
          p_len++;
          check("pulse_stable", int'(act_kind != p_kind || int'(bus.moeda_in) != p_code), 0);
        end else if (in_p) begin
          in_p = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: kind %0d code %0d len %0d at %0d, expected none",
                     p_kind, p_code, p_len, p_start);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_kind", p_kind, e.kind);
            check("pulse_code", p_code, e.code);
            check("pulse_len", p_len, e.len);
            if (e.abs_start >= 0) check("pulse_start", p_start, e.abs_start);
            else                  check("pulse_gap", p_start - last_end, e.gap);
          end
          last_end = cyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, r;
    reset = 1'b1;
    bus.coin_det_raw = 1'b0;
    bus.coin_diam    = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_moeda_in", int'(bus.moeda_in), 0);
    check("reset_sensor", int'(bus.sensor_moedas), 0);
    check("reset_reject", int'(bus.reject_gate), 0);
    check("reset_busy", int'(bus.busy), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Bouncing detector: never qualifies.
    coin_on(4'd9, n);
    @(posedge clk); #1; bus.coin_det_raw = 1'b0;
    @(posedge clk); #1; bus.coin_det_raw = 1'b1;
    @(posedge clk); #1; coin_off();
    drain("glitch");

    // Clean R$0.25: first strobe 2 + 4 + 2 + 1 cycles after the detector rises.
    coin_on(4'd9, n);
    push(K_EMIT, int'(COIN_25), 3, n + 9, 0);
    coin_hold(4'd9, 19, 1'b0);
    check("busy_wait_clear", int'(bus.busy), 1);
    coin_hold(4'd9, 1, 1'b0);
    coin_off();
    repeat (5) @(posedge clk);
    #1;
    check("busy_before_clear", int'(bus.busy), 1);
    @(posedge clk); #1;
    check("busy_after_clear", int'(bus.busy), 0);
    drain("coin25");

    coin_on(4'd11, n);
    push(K_EMIT, int'(COIN_50), 3, n + 9, 0);
    coin_hold(4'd11, 20, 1'b0);
    coin_off();
    drain("coin50");

    coin_on(4'd7, n);
    push(K_REJ, 0, 8, n + 9, 0);
    coin_hold(4'd7, 20, 1'b0);
    coin_off();
    drain("unknown7");

    coin_on(4'd13, n);
`ifdef COIN_ACCEPT_100_EN
    push(K_EMIT, int'(COIN_50), 3, n + 9, 0);
    push(K_EMIT, int'(COIN_50), 3, -1, 4);
`else
    push(K_REJ, 0, 8, n + 9, 0);
`endif
    coin_hold(4'd13, 24, 1'b0);
    coin_off();
    drain("coin100");

    // Diameter alternating 11/12: four failed tries, evaluations at +9,+12,+15,+18.
    coin_on(4'd11, n);
    push(K_REJ, 0, 8, n + 18, 0);
    coin_hold(4'd11, 30, 1'b1);
    coin_off();
    drain("unstable");

    // Reset in the second strobe cycle, detector still high: fresh debounce afterwards.
    coin_on(4'd9, n);
    coin_hold(4'd9, 10, 1'b0);
    check("emit2_sensor", int'(bus.sensor_moedas), 1);
    check("emit2_code", int'(bus.moeda_in), 1);
    reset = 1'b1;
    #1;
    check("abort_moeda_in", int'(bus.moeda_in), 0);
    check("abort_sensor", int'(bus.sensor_moedas), 0);
    check("abort_reject", int'(bus.reject_gate), 0);
    check("abort_busy", int'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    r = cyc;
    push(K_EMIT, int'(COIN_25), 3, r + 9, 0);
    coin_hold(4'd9, 20, 1'b0);
    coin_off();
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
